// File: rtl/fb_reader_if.sv
// Wishbone bus bundle between the framebuffer reader (master) and the SDRAM
// arbiter (slave). clk/rst are carried as interface ports so both sides see
// the same clock and synchronous active-high reset.
//   master: drives cyc/stb/we/sel/cti/bte/adr, receives dat_sm/ack
//   slave : the mirror image
interface fb_reader_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] adr;
  logic [31:0] dat_sm;
  logic        ack;

  modport master (input clk, rst, dat_sm, ack,
                  output cyc, stb, we, sel, cti, bte, adr);
  modport slave  (input clk, rst, cyc, stb, we, sel, cti, bte, adr,
                  output dat_sm, ack);
endinterface

// File: rtl/fb_reader.sv
// fb_reader: Wishbone read master that scans the framebuffer in raster order
// with bounded bursts and streams pixels through a show-ahead FIFO.
//   wshb_ifm   : Wishbone master (clk, sync active-high rst, classic reads)
//   pix_data   : pixel word at FIFO head
//   pix_valid  : FIFO not empty
//   pix_ready  : consumer pops head when pix_valid & pix_ready
//   pix_sof    : head word is pixel (0,0)
//   pix_eol    : head word is last pixel of its line
//   fifo_level : words currently stored
module fb_reader #(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter logic [31:0] BASE_ADR   = 32'd0,
  parameter int          BURST      = 64,
  parameter int          FIFO_DEPTH = 256
) (
  fb_reader_if.master                  wshb_ifm,
  output logic [31:0]                  pix_data,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic                         pix_sof,
  output logic                         pix_eol,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int VW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [PW-1:0] PIX_LAST   = PW'(HDISP - 1);
  localparam logic [VW-1:0] LINE_LAST  = VW'(VDISP - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t        state_q;
  logic          cyc_q;
  logic [31:0]   adr_q, adr_d;
  logic [PW-1:0] pixel_q, pixel_d;
  logic [VW-1:0] line_q, line_d;
  logic [BW-1:0] burst_q;

  logic [33:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;

  logic ack_v, push, pop, pix_last, frame_last, admit;

  // An ack only counts while our cycle is open.
  assign ack_v      = cyc_q & wshb_ifm.ack;
  assign push       = ack_v;
  assign pop        = pix_ready & pix_valid;
  assign pix_last   = (pixel_q == PIX_LAST);
  assign frame_last = pix_last & (line_q == LINE_LAST);
  // Admission guarantees a whole burst fits, so the FIFO never overflows.
  assign admit      = (LW'(FIFO_DEPTH) - level_q) >= LW'(BURST);

  always_comb begin
    pixel_d = pixel_q + 1'b1;
    line_d  = line_q;
    if (pix_last) begin
      pixel_d = '0;
      line_d  = (line_q == LINE_LAST) ? '0 : line_q + 1'b1;
    end
  end

  assign adr_d = BASE_ADR + ((32'(line_d) * 32'(HDISP)) + 32'(pixel_d)) * 32'd4;

  // Burst FSM. The admission check is also done at GAP's exit edge, so the
  // bus is released for exactly one cycle between bursts when space allows.
  always_ff @(posedge wshb_ifm.clk) begin
    if (wshb_ifm.rst) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      adr_q   <= BASE_ADR;
      pixel_q <= '0;
      line_q  <= '0;
      burst_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (admit) begin
          state_q <= S_BURST;
          cyc_q   <= 1'b1;
        end
        S_BURST: if (ack_v) begin
          pixel_q <= pixel_d;
          line_q  <= line_d;
          adr_q   <= adr_d;
          if (burst_q == BURST_LAST || frame_last) begin
            state_q <= S_GAP;
            cyc_q   <= 1'b0;
            burst_q <= '0;
          end else begin
            burst_q <= burst_q + 1'b1;
          end
        end
        S_GAP: begin
          state_q <= admit ? S_BURST : S_IDLE;
          cyc_q   <= admit;
        end
        default: begin
          state_q <= S_IDLE;
          cyc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wshb_ifm.cyc = cyc_q;
  assign wshb_ifm.stb = cyc_q;
  assign wshb_ifm.we  = 1'b0;
  assign wshb_ifm.sel = 4'b1111;
  assign wshb_ifm.cti = 3'b000;
  assign wshb_ifm.bte = 2'b00;
  assign wshb_ifm.adr = adr_q;

  // FIFO storage: {sof, eol, data}; flags describe the word being acked.
  always_ff @(posedge wshb_ifm.clk) begin
    if (push)
      mem_q[wr_q] <= {(pixel_q == '0) && (line_q == '0), pix_last, wshb_ifm.dat_sm};
  end

  always_ff @(posedge wshb_ifm.clk) begin
    if (wshb_ifm.rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Show-ahead head.
  assign {pix_sof, pix_eol, pix_data} = mem_q[rd_q];
  assign pix_valid  = (level_q != '0);
  assign fifo_level = level_q;
endmodule

// File: tb/tb_fb_reader.sv
module tb_fb_reader;
  localparam int AH = 800, AV = 480, AB = 64, AD = 256;
  localparam int BH = 16,  BV = 4,   BB = 8,  BD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA, rstB, rdyA, rdyB;
  logic [31:0] datA, datB;
  logic vA, vB, sofA, sofB, eolA, eolB;
  logic [8:0] lvlA;
  logic [4:0] lvlB;

  fb_reader_if ifA (.clk(clk), .rst(rstA));
  fb_reader_if ifB (.clk(clk), .rst(rstB));

  fb_reader #(.HDISP(AH), .VDISP(AV), .BASE_ADR(32'd0), .BURST(AB), .FIFO_DEPTH(AD)) dA (
    .wshb_ifm(ifA.master), .pix_data(datA), .pix_valid(vA), .pix_ready(rdyA),
    .pix_sof(sofA), .pix_eol(eolA), .fifo_level(lvlA));

  fb_reader #(.HDISP(BH), .VDISP(BV), .BASE_ADR(32'd0), .BURST(BB), .FIFO_DEPTH(BD)) dB (
    .wshb_ifm(ifB.master), .pix_data(datB), .pix_valid(vB), .pix_ready(rdyB),
    .pix_sof(sofB), .pix_eol(eolB), .fifo_level(lvlB));

  int n_tot = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Memory image: bijective hash of the byte address.
  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hDEAD_BEEF;
  endfunction

  // ---------------- slave A: optional wait states, burst/gap monitor -------
  bit waitA = 0, chkgapA = 0;
  int ackcntA = 0, burstsA = 0;
  logic [31:0] adrlogA[$];

  initial begin : slvA
    bit pend = 0, pcyc = 0, seenfall = 0;
    int wc = 0, inburst = 0, lowlen = 0;
    logic [31:0] padr = '0;
    ifA.ack = 1'b0; ifA.dat_sm = '0;
    forever begin
      @(negedge clk);
      if (rstA) begin
        ifA.ack = 1'b0; pend = 0; pcyc = 0; seenfall = 0; inburst = 0; lowlen = 0;
        ackcntA = 0; adrlogA.delete();
      end else begin
        if (ifA.cyc && !pcyc) begin
          burstsA++;
          if (chkgapA && seenfall) chk("gap_len", lowlen, 1);
        end
        if (!ifA.cyc && pcyc) begin
          if (chkgapA) chk("burst_len", inburst, AB);
          inburst = 0; seenfall = 1; lowlen = 0;
        end
        if (!ifA.cyc) lowlen++;
        pcyc = ifA.cyc;
        if (pend) chk("stb_adr_stable", {ifA.cyc, ifA.stb, ifA.adr}, {2'b11, padr});
        if (ifA.cyc && ifA.stb) begin
          if (!pend) begin
            pend = 1; padr = ifA.adr;
            wc = waitA ? $urandom_range(0, 5) : 0;
          end
          if (wc == 0) begin
            ifA.ack = 1'b1; ifA.dat_sm = img(ifA.adr); pend = 0;
            ackcntA++; inburst++; adrlogA.push_back(ifA.adr);
            chk("A_push_full", lvlA == 9'(AD), 1'b0);
          end else begin
            ifA.ack = 1'b0; wc--;
          end
        end else begin
          ifA.ack = 1'b0; pend = 0;
        end
      end
    end
  end

  // ---------------- stream monitor A: reference raster model --------------
  int kA = 0;
  logic [33:0] capA[$];
  initial begin : monA
    int p;
    forever begin
      @(negedge clk); #2;
      if (rstA) begin kA = 0; capA.delete(); end
      else if (vA && rdyA) begin
        p = kA % (AH * AV);
        chk($sformatf("streamA_%0d", kA), {sofA, eolA, datA},
            {p == 0, (p % AH) == AH - 1, img(32'(p) * 4)});
        capA.push_back({sofA, eolA, datA});
        kA++;
      end
    end
  end

  // ---------------- slave B: zero wait, optional stray acks while idle -----
  bit junkB = 0;
  initial begin : slvB
    ifB.ack = 1'b0; ifB.dat_sm = '0;
    forever begin
      @(negedge clk);
      if (rstB) ifB.ack = 1'b0;
      else if (ifB.cyc && ifB.stb) begin
        ifB.ack = 1'b1; ifB.dat_sm = img(ifB.adr);
      end else begin
        ifB.ack = junkB ? 1'($urandom_range(0, 1)) : 1'b0;
        ifB.dat_sm = $urandom;
      end
    end
  end

  int kB = 0, nwrapB = 0, nl1B = 0;
  logic [33:0] capB[$];
  initial begin : monB
    bit wrap_pend = 0, l1_pend = 0;
    int p;
    forever begin
      @(negedge clk); #2;
      if (rstB) begin kB = 0; capB.delete(); wrap_pend = 0; l1_pend = 0; end
      else begin
        if (wrap_pend) begin
          chk("wrap_adr_cyc", {ifB.cyc, ifB.adr}, {1'b0, 32'd0});
          nwrapB++;
        end
        if (l1_pend) begin
          chk("lvl1_pushpop", lvlB, 5'd1);
          nl1B++;
        end
        wrap_pend = ifB.cyc && ifB.ack && ifB.adr == 32'd252;
        l1_pend   = ifB.cyc && ifB.ack && vB && rdyB && lvlB == 5'd1;
        if (ifB.cyc && ifB.ack) chk("B_push_full", lvlB == 5'(BD), 1'b0);
        if (vB && rdyB) begin
          p = kB % (BH * BV);
          chk($sformatf("streamB_%0d", kB), {sofB, eolB, datB},
              {p == 0, (p % BH) == BH - 1, img(32'(p) * 4)});
          capB.push_back({sofB, eolB, datB});
          kB++;
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct { int idx; logic [31:0] adr; logic sof; logic eol; } vec_t;
  vec_t tv[9];

  task automatic pulse_reset_A();
    @(negedge clk); rstA = 1'b1;
    repeat (2) @(negedge clk);
    rstA = 1'b0;
  endtask

  initial begin : main
    int b0;
    rstA = 1'b1; rstB = 1'b1; rdyA = 1'b0; rdyB = 1'b0;
    repeat (3) @(negedge clk); #2;

    // Reset state and constant bus fields
    chk("A_reset", {ifA.cyc, ifA.stb, ifA.adr, vA, lvlA}, '0);
    chk("B_reset", {ifB.cyc, ifB.stb, ifB.adr, vB, lvlB}, '0);
    chk("A_consts", {ifA.we, ifA.sel, ifA.cti, ifA.bte}, {1'b0, 4'hf, 3'b000, 2'b00});

    // Streaming at full rate: addresses, flags and burst/gap shape
    tv[0] = '{0,    32'd0,    1'b1, 1'b0};
    tv[1] = '{1,    32'd4,    1'b0, 1'b0};
    tv[2] = '{2,    32'd8,    1'b0, 1'b0};
    tv[3] = '{63,   32'd252,  1'b0, 1'b0};
    tv[4] = '{64,   32'd256,  1'b0, 1'b0};
    tv[5] = '{798,  32'd3192, 1'b0, 1'b0};
    tv[6] = '{799,  32'd3196, 1'b0, 1'b1};
    tv[7] = '{1599, 32'd6396, 1'b0, 1'b1};
    tv[8] = '{2399, 32'd9596, 1'b0, 1'b1};
    @(negedge clk);
    rdyA = 1'b1; chkgapA = 1; rstA = 1'b0;
    for (int c = 0; c < 4000 && kA < 2500; c++) @(negedge clk);
    chk("T1_done", kA >= 2500, 1'b1);
    chkgapA = 0;
    for (int i = 0; i < 9; i++)
      chk($sformatf("vecA_%0d", tv[i].idx), {adrlogA[tv[i].idx], capA[tv[i].idx][33:32]},
          {tv[i].adr, tv[i].sof, tv[i].eol});

    // Frame wrap on the small instance, with stray acks while cyc is low
    junkB = 1; rdyB = 1'b1; rstB = 1'b0;
    for (int c = 0; c < 1000 && kB < 140; c++) @(negedge clk);
    chk("T2_done", kB >= 140, 1'b1);
    chk("wrap_seen", nwrapB >= 2, 1'b1);
    chk("lvl1_seen", nl1B > 0, 1'b1);
    chk("B_eol15", capB[15][33:32], 2'b01);
    chk("B_eol63", capB[63][33:32], 2'b01);
    chk("B_sof64", capB[64], {2'b10, img(32'd0)});
    chk("B_w65",   capB[65], {2'b00, img(32'd4)});

    // Backpressure and burst admission boundary
    rdyA = 1'b0; waitA = 0;
    pulse_reset_A();
    for (int c = 0; c < 600 && lvlA != 9'd256; c++) @(negedge clk);
    b0 = burstsA;
    repeat (100) @(negedge clk); #2;
    chk("bp_level_full", lvlA, 9'd256);
    chk("bp_no_cyc", {burstsA - b0, 31'(ifA.cyc)}, '0);
    rdyA = 1'b1;
    repeat (63) @(negedge clk);
    rdyA = 1'b0;
    repeat (20) @(negedge clk); #2;
    chk("bp_level_193", lvlA, 9'd193);
    chk("bp_free63_no_burst", burstsA - b0, 0);
    @(negedge clk); rdyA = 1'b1;
    @(negedge clk); rdyA = 1'b0;
    repeat (100) @(negedge clk); #2;
    chk("bp_one_burst", burstsA - b0, 1);
    chk("bp_refill", lvlA, 9'd256);
    chk("bp_popped", kA, 64);

    // Random wait states and random consumer
    waitA = 1;
    pulse_reset_A();
    for (int c = 0; c < 10000 && kA < 600; c++) begin
      @(negedge clk); rdyA = 1'($urandom_range(0, 1));
    end
    chk("T4_done", kA >= 600, 1'b1);

    // Reset in the middle of a burst
    waitA = 0;
    @(negedge clk); rdyA = 1'b1;
    pulse_reset_A();
    for (int c = 0; c < 200 && ackcntA < 10; c++) @(negedge clk);
    chk("pre_rst_acks", ackcntA >= 10, 1'b1);
    chk("pre_rst_cyc", ifA.cyc, 1'b1);
    rstA = 1'b1;
    @(negedge clk); #2;
    chk("rst_mid", {ifA.cyc, ifA.stb, vA, ifA.adr, lvlA}, '0);
    @(negedge clk); rstA = 1'b0;
    for (int c = 0; c < 100 && kA < 5; c++) @(negedge clk);
    chk("restart_words", kA >= 5, 1'b1);
    chk("restart_first", capA[0], {2'b10, img(32'd0)});
    chk("restart_adr0", adrlogA[0], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
